// File: rtl/regfile_writeback_queue_pkg.sv
// Constants and types shared by the writeback queue, register file and decode.
package regfile_writeback_queue_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_writeback_queue_wbq_match.sv
// Youngest-match search over the queued writes for one read address.
module wbq_match
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    input  logic [DEPTH*ADDR_WIDTH-1:0] i_entryRw,
    input  logic [DEPTH*DATA_WIDTH-1:0] i_entryData,
    input  logic [$clog2(DEPTH)-1:0]    i_head,
    input  logic [$clog2(DEPTH):0]      i_count,
    output logic                        o_hit,
    output logic [DATA_WIDTH-1:0]       o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (((PTR_W+1)'(k) < i_count) &&
                (i_addr != ADDR_WIDTH'(ZERO_REG)) &&
                (i_entryRw[w_idx*ADDR_WIDTH +: ADDR_WIDTH] == i_addr)) begin
                o_hit  = 1'b1;
                o_data = i_entryData[w_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue driving the register file write port, with a pending scoreboard and forwarding.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  WbValid,
    output logic                  WbReady,
    input  logic [ADDR_WIDTH-1:0] WbRW,
    input  logic [DATA_WIDTH-1:0] WbData,
    input  logic                  Hold,
    output logic [ADDR_WIDTH-1:0] RW,
    output logic [DATA_WIDTH-1:0] BusW,
    output logic                  RegWr,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    output logic                  FwdHitA,
    output logic                  FwdHitB,
    output logic [DATA_WIDTH-1:0] FwdDataA,
    output logic [DATA_WIDTH-1:0] FwdDataB,
    output logic [NUM_REGS-1:0]   Pending,
    output logic                  Full,
    output logic                  Empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0]       r_rw   [DEPTH];
    logic [DATA_WIDTH-1:0]       r_data [DEPTH];
    logic [PTR_W-1:0]            r_head;
    logic [PTR_W-1:0]            r_tail;
    logic [PTR_W:0]              r_count;

    logic                        w_push;
    logic                        w_pop;
    logic [DEPTH*ADDR_WIDTH-1:0] w_rwFlat;
    logic [DEPTH*DATA_WIDTH-1:0] w_dataFlat;
    logic [PTR_W-1:0]            w_idx;

    assign Full    = (r_count == (PTR_W+1)'(DEPTH));
    assign Empty   = (r_count == '0);
    assign WbReady = !Full;
    assign RegWr   = !Empty && !Hold;
    assign RW      = Empty ? '0 : r_rw[r_head];
    assign BusW    = Empty ? '0 : r_data[r_head];

    // A write to the zero register completes the handshake but is dropped.
    assign w_push = WbValid && WbReady && (WbRW != ADDR_WIDTH'(ZERO_REG));
    assign w_pop  = RegWr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_rw[r_tail]   <= WbRW;
                r_data[r_tail] <= WbData;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    always_comb begin
        w_rwFlat   = '0;
        w_dataFlat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_rwFlat[k*ADDR_WIDTH +: ADDR_WIDTH]   = r_rw[k];
            w_dataFlat[k*DATA_WIDTH +: DATA_WIDTH] = r_data[k];
        end
    end

    // Only occupied slots (head .. head+count-1) contribute to the scoreboard.
    always_comb begin
        Pending = '0;
        w_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (((PTR_W+1)'(k) < r_count) && (r_rw[w_idx] != ADDR_WIDTH'(ZERO_REG))) begin
                Pending[r_rw[w_idx]] = 1'b1;
            end
        end
    end

    wbq_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_matchA (
        .i_addr      (RA),
        .i_entryRw   (w_rwFlat),
        .i_entryData (w_dataFlat),
        .i_head      (r_head),
        .i_count     (r_count),
        .o_hit       (FwdHitA),
        .o_data      (FwdDataA)
    );

    wbq_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_matchB (
        .i_addr      (RB),
        .i_entryRw   (w_rwFlat),
        .i_entryData (w_dataFlat),
        .i_head      (r_head),
        .i_count     (r_count),
        .o_hit       (FwdHitB),
        .o_data      (FwdDataB)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed self-checking bench for regfile_writeback_queue with hand-computed expectations.
module tb_regfile_writeback_queue;

    logic        Clk;
    logic        Reset;
    logic        WbValid;
    logic        WbReady;
    logic [4:0]  WbRW;
    logic [63:0] WbData;
    logic        Hold;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic        FwdHitA;
    logic        FwdHitB;
    logic [63:0] FwdDataA;
    logic [63:0] FwdDataB;
    logic [31:0] Pending;
    logic        Full;
    logic        Empty;

    int checkCount = 0;
    int failCount  = 0;

    regfile_writeback_queue #(
        .DEPTH      (4),
        .DATA_WIDTH (64),
        .ADDR_WIDTH (5)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .WbValid  (WbValid),
        .WbReady  (WbReady),
        .WbRW     (WbRW),
        .WbData   (WbData),
        .Hold     (Hold),
        .RW       (RW),
        .BusW     (BusW),
        .RegWr    (RegWr),
        .RA       (RA),
        .RB       (RB),
        .FwdHitA  (FwdHitA),
        .FwdHitB  (FwdHitB),
        .FwdDataA (FwdDataA),
        .FwdDataB (FwdDataB),
        .Pending  (Pending),
        .Full     (Full),
        .Empty    (Empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] rw, input logic [63:0] data, input logic hold);
        WbValid = valid;
        WbRW    = rw;
        WbData  = data;
        Hold    = hold;
        #1;
    endtask

    // Moves just past the next rising edge, leaving time for outputs to settle.
    task automatic advanceClock();
        @(posedge Clk);
        #1;
    endtask

    logic [4:0]  expRw   [4];
    logic [63:0] expData [4];

    initial begin
        Reset = 1'b1;
        RA = 5'd0;
        RB = 5'd0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        advanceClock();
        advanceClock();
        Reset = 1'b0;
        #1;

        checkOutput("rst_empty",   Empty,    64'd1);
        checkOutput("rst_full",    Full,     64'd0);
        checkOutput("rst_ready",   WbReady,  64'd1);
        checkOutput("rst_regwr",   RegWr,    64'd0);
        checkOutput("rst_rw",      RW,       64'd0);
        checkOutput("rst_busw",    BusW,     64'd0);
        checkOutput("rst_pending", Pending,  64'd0);
        checkOutput("rst_hitA",    FwdHitA,  64'd0);
        checkOutput("rst_dataA",   FwdDataA, 64'd0);
        checkOutput("rst_hitB",    FwdHitB,  64'd0);

        // Single push with Hold low retires in the following cycle.
        applyStimulus(1'b1, 5'd3, 64'hA5, 1'b0);
        advanceClock();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        RB = 5'd3;
        #1;
        checkOutput("single_regwr",   RegWr,    64'd1);
        checkOutput("single_rw",      RW,       64'd3);
        checkOutput("single_busw",    BusW,     64'hA5);
        checkOutput("single_pending", Pending,  64'h8);
        checkOutput("single_hitB",    FwdHitB,  64'd1);
        checkOutput("single_dataB",   FwdDataB, 64'hA5);
        advanceClock();
        checkOutput("single_drained", Empty,    64'd1);
        checkOutput("single_pend0",   Pending,  64'd0);
        checkOutput("single_regwr0",  RegWr,    64'd0);

        // Fill under Hold; RW=5 appears twice so the youngest must win.
        expRw[0] = 5'd5; expData[0] = 64'd1;
        expRw[1] = 5'd6; expData[1] = 64'd2;
        expRw[2] = 5'd5; expData[2] = 64'd3;
        expRw[3] = 5'd7; expData[3] = 64'd4;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, expRw[i], expData[i], 1'b1);
            advanceClock();
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1);
        RA = 5'd5;
        RB = 5'd6;
        #1;
        checkOutput("fill_full",    Full,     64'd1);
        checkOutput("fill_ready",   WbReady,  64'd0);
        checkOutput("fill_regwr",   RegWr,    64'd0);
        checkOutput("fill_rw",      RW,       64'd5);
        checkOutput("fill_busw",    BusW,     64'd1);
        checkOutput("fill_pending", Pending,  64'hE0);
        checkOutput("fill_hitA",    FwdHitA,  64'd1);
        checkOutput("fill_dataA",   FwdDataA, 64'd3);
        checkOutput("fill_dataB",   FwdDataB, 64'd2);

        applyStimulus(1'b1, 5'd9, 64'h99, 1'b1);
        advanceClock();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1);
        checkOutput("reject_full",    Full,    64'd1);
        checkOutput("reject_pending", Pending, 64'hE0);

        // Release Hold: four back-to-back retirements in order.
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_regwr", RegWr, 64'd1);
            checkOutput("drain_rw",    RW,    64'(expRw[i]));
            checkOutput("drain_busw",  BusW,  expData[i]);
            advanceClock();
        end
        checkOutput("drain_empty", Empty, 64'd1);
        checkOutput("drain_regwr0", RegWr, 64'd0);

        // Writes to the zero register are accepted and dropped.
        RA = 5'd31;
        applyStimulus(1'b1, 5'd31, 64'hFF, 1'b0);
        checkOutput("zero_ready", WbReady, 64'd1);
        advanceClock();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("zero_empty",   Empty,   64'd1);
        checkOutput("zero_regwr",   RegWr,   64'd0);
        checkOutput("zero_pending", Pending, 64'd0);
        checkOutput("zero_hitA",    FwdHitA, 64'd0);

        // Three entries under Hold (tail wraps), then push and pop on one edge.
        expRw[0] = 5'd1; expData[0] = 64'h10;
        expRw[1] = 5'd2; expData[1] = 64'h20;
        expRw[2] = 5'd4; expData[2] = 64'h40;
        expRw[3] = 5'd8; expData[3] = 64'h80;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, expRw[i], expData[i], 1'b1);
            advanceClock();
        end
        applyStimulus(1'b1, expRw[3], expData[3], 1'b0);
        checkOutput("wrap_pre_regwr", RegWr, 64'd1);
        checkOutput("wrap_pre_rw",    RW,    64'd1);
        advanceClock();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        RA = 5'd4;
        #1;
        checkOutput("wrap_full",    Full,     64'd0);
        checkOutput("wrap_empty",   Empty,    64'd0);
        checkOutput("wrap_pending", Pending,  64'h114);
        checkOutput("wrap_dataA",   FwdDataA, 64'h40);
        for (int i = 1; i < 4; i++) begin
            checkOutput("wrap_regwr", RegWr, 64'd1);
            checkOutput("wrap_rw",    RW,    64'(expRw[i]));
            checkOutput("wrap_busw",  BusW,  expData[i]);
            advanceClock();
        end
        checkOutput("wrap_drained", Empty, 64'd1);

        // Reset mid-drain discards the remaining entries.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(11 + i), 64'h111 * 64'(i + 1), 1'b1);
            advanceClock();
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("midrst_regwr", RegWr, 64'd1);
        checkOutput("midrst_rw",    RW,    64'd11);
        Reset = 1'b1;
        advanceClock();
        Reset = 1'b0;
        #1;
        checkOutput("midrst_regwr0",  RegWr,   64'd0);
        checkOutput("midrst_empty",   Empty,   64'd1);
        checkOutput("midrst_pending", Pending, 64'd0);
        for (int i = 0; i < 4; i++) begin
            advanceClock();
            checkOutput("midrst_quiet_regwr", RegWr, 64'd0);
            checkOutput("midrst_quiet_rw",    RW,    64'd0);
            checkOutput("midrst_quiet_busw",  BusW,  64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
